resp_capture_checker: RTL and testbench
=======================================

Name: resp_capture_checker

Overview:
- Synthesizable response-side block for the ISCAS-85 aging benches; the counterpart of the vector-applying stimulus side.
- Accepts each output vector of the circuit under test via a valid/ready handshake and fetches the golden vector for the same index from a synchronous expected-response ROM.
- Compares the two vectors, counts mismatches, records the first failing index and compacts all responses into a MISR signature.
- Replaces per-cycle file dumps when long aging runs are checked in gate-level/HSPICE co-simulation.

Parameters:
- VEC_W, 25, response vector width (c1908 has 25 outputs)
- VEC_LEN, 31, number of vectors per run (must be at least 1)
- ADDR_W, 5, expected-ROM address width; 2^ADDR_W >= VEC_LEN
- MISR_POLY, 25'h0000009, MISR feedback polynomial (VEC_W bits)
- CNT_W, 16, mismatch counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
- resp_valid  in  1  response vector present on resp_data
- resp_data  in  VEC_W  circuit-under-test output vector
- resp_ready  out  1  block accepts resp_data this cycle
- exp_rd_en  out  1  expected-ROM read strobe
- exp_addr  out  ADDR_W  expected-ROM address
- exp_data  in  VEC_W  ROM data, valid the cycle after exp_rd_en
- busy  out  1  run in progress
- done  out  1  run complete; sticky until the next accepted start
- pass  out  1  done and mismatch_cnt==0
- mismatch_cnt  out  CNT_W  number of vectors with any differing bit; saturates at all-ones
- first_fail_idx  out  ADDR_W  index of the first mismatching vector
- first_fail_vld  out  1  first_fail_idx is meaningful
- signature  out  VEC_W  MISR state

Behaviour:
- Reset values: every output is 0, the state is IDLE, and the internal idx, exp_q and sig registers are 0. Reset asserted mid-run aborts the run immediately with no further ROM reads.
- FSM states: IDLE, FETCH, LOAD, READY, DONE.
- IDLE or DONE plus start: clear idx, mismatch_cnt, first_fail_*, signature, done and pass, then go to FETCH. start in any other state is ignored.
- FETCH: exp_rd_en=1 and exp_addr=idx for exactly this cycle, then go to LOAD.
- LOAD: exp_q <= exp_data, then go to READY.
- READY: resp_ready=1. When resp_valid=1 the handshake completes in that cycle and the block performs all of the following:
  - mismatch = (resp_data != exp_q).
  - If mismatch, mismatch_cnt increments (saturating). If first_fail_vld is 0, first_fail_idx <= idx and first_fail_vld <= 1.
  - signature <= {signature[VEC_W-2:0],1'b0} ^ (signature[VEC_W-1] ? MISR_POLY : 0) ^ resp_data.
  - If idx == VEC_LEN-1, go to DONE. Otherwise idx <= idx+1, exp_rd_en=1 and exp_addr=idx+1 in this same cycle, then go to LOAD.
- In READY with resp_valid=0 the block holds all state; there is no timeout.
- resp_ready is 0 in every state other than READY, so resp_valid there has no effect.
- DONE: done=1, pass=(mismatch_cnt==0), busy=0. busy=1 in FETCH, LOAD and READY.
- Throughput: one vector per 2 cycles in steady state. The first vector is accepted no earlier than the 3rd cycle after start.
- All outputs are registered except resp_ready, exp_rd_en and exp_addr, which decode from state and idx.
- Results (mismatch_cnt, first_fail_*, signature) stay stable in DONE until the next start.

Test Plan:
- Clean run: VEC_LEN=31 with ROM contents equal to the responses, resp_valid held at 1 -> done after 31 handshakes, pass=1, mismatch_cnt=0, first_fail_vld=0; handshakes occur every 2 cycles.
- Injected faults: flip bit 3 of vector 7 and bit 0 of vector 20 -> mismatch_cnt=2, first_fail_idx=7, first_fail_vld=1, pass=0.
- MISR: VEC_W=4, VEC_LEN=2, MISR_POLY=4'h3, responses 4'h9 then 4'h6 -> signature 4'h9 after vector 0 and 4'h7 at done.
- Backpressure and protocol: resp_valid=0 for 5 cycles in READY, plus start pulsed mid-run -> no state change, no extra ROM reads, run completes normally.
- Reset mid-run: rst_n=0 after vector 10 -> all outputs 0 asynchronously; a new start gives results for a full fresh run.
- Restart from DONE: start pulse -> done, pass, mismatch_cnt and signature clear in the next cycle and exp_addr=0 is fetched.

Source files
------------

// File: rtl/resp_capture_checker.sv
// rtl/resp_capture_checker.sv - response capture, golden compare, mismatch count and MISR compaction
module resp_capture_checker #(
  parameter int                VEC_W     = 25,
  parameter int                VEC_LEN   = 31,
  parameter int                ADDR_W    = 5,
  parameter logic [VEC_W-1:0]  MISR_POLY = 25'h0000009,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [VEC_W-1:0]  resp_data,
  output logic              resp_ready,
  output logic              exp_rd_en,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [VEC_W-1:0]  exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld,
  output logic [VEC_W-1:0]  signature
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_READY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [VEC_W-1:0]  exp_q;

  logic              hs;
  logic              last_vec;
  logic              fetch_next;
  logic              mismatch;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [VEC_W-1:0]  sig_nxt;

  // Handshake and the prefetch of the next golden vector are decoded from state so
  // the ROM read overlaps the accepting cycle, giving one vector every two cycles.
  assign resp_ready = (state == S_READY);
  assign hs         = resp_ready && resp_valid;
  assign last_vec   = (idx == LAST_IDX);
  assign fetch_next = hs && !last_vec;
  assign exp_rd_en  = (state == S_FETCH) || fetch_next;
  assign exp_addr   = (state == S_FETCH) ? idx :
                      fetch_next         ? idx + ADDR_W'(1) : '0;

  assign mismatch = (resp_data != exp_q);
  assign cnt_nxt  = (mismatch && (mismatch_cnt != {CNT_W{1'b1}})) ?
                    mismatch_cnt + CNT_W'(1) : mismatch_cnt;
  assign sig_nxt  = {signature[VEC_W-2:0], 1'b0} ^
                    (signature[VEC_W-1] ? MISR_POLY : {VEC_W{1'b0}}) ^ resp_data;

  // Run sequencer; all status outputs and results are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      exp_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      signature      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx            <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            signature      <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          exp_q <= exp_data;
          state <= S_READY;
        end
        S_READY: begin
          if (resp_valid) begin
            mismatch_cnt <= cnt_nxt;
            signature    <= sig_nxt;
            if (mismatch && !first_fail_vld) begin
              first_fail_idx <= idx;
              first_fail_vld <= 1'b1;
            end
            if (last_vec) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_nxt == '0);
              state <= S_DONE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= S_LOAD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_capture_checker.sv
// tb/tb_resp_capture_checker.sv - directed self-checking bench for resp_capture_checker
module tb_resp_capture_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        resp_valid;
  logic [24:0] resp_data;
  logic        resp_ready;
  logic        exp_rd_en;
  logic [4:0]  exp_addr;
  logic [24:0] exp_data;
  logic        busy, done, pass;
  logic [15:0] mismatch_cnt;
  logic [4:0]  first_fail_idx;
  logic        first_fail_vld;
  logic [24:0] signature;

  logic        m_start, m_resp_valid, m_resp_ready, m_exp_rd_en, m_exp_addr;
  logic [3:0]  m_resp_data, m_exp_data, m_signature;
  logic        m_busy, m_done, m_pass, m_first_fail_idx, m_first_fail_vld;
  logic [15:0] m_mismatch_cnt;

  logic [24:0] rom [0:30];
  logic [24:0] rsp [0:30];
  logic [3:0]  m_rom [0:1];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int nhs, bad_gap, first_lat;

  always #5 clk = ~clk;

  resp_capture_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .exp_rd_en(exp_rd_en), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld), .signature(signature)
  );

  resp_capture_checker #(.VEC_W(4), .VEC_LEN(2), .ADDR_W(1), .MISR_POLY(4'h3), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .resp_valid(m_resp_valid), .resp_data(m_resp_data),
    .resp_ready(m_resp_ready), .exp_rd_en(m_exp_rd_en), .exp_addr(m_exp_addr), .exp_data(m_exp_data),
    .busy(m_busy), .done(m_done), .pass(m_pass), .mismatch_cnt(m_mismatch_cnt),
    .first_fail_idx(m_first_fail_idx), .first_fail_vld(m_first_fail_vld), .signature(m_signature)
  );

  // synchronous golden ROMs, data one cycle after the read strobe
  always @(posedge clk) begin
    if (exp_rd_en) exp_data <= rom[exp_addr];
    if (m_exp_rd_en) m_exp_data <= m_rom[m_exp_addr];
  end

  always @(posedge clk) if (exp_rd_en) rd_cnt <= rd_cnt + 1;

  function automatic logic [24:0] misr_model();
    logic [24:0] s;
    s = '0;
    for (int i = 0; i < 31; i++) s = {s[23:0], 1'b0} ^ (s[24] ? 25'h0000009 : 25'h0) ^ rsp[i];
    return s;
  endfunction

  task automatic set_clean();
    for (int i = 0; i < 31; i++) rsp[i] = rom[i];
  endtask

  task automatic set_faults();
    set_clean();
    rsp[7]  = rsp[7]  ^ 25'h0000008;
    rsp[20] = rsp[20] ^ 25'h0000001;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Serves responses from rsp[], starting at the negedge where the DUT sits in FETCH.
  task automatic serve(input int stall_idx, input bit mid_start, input int stop_after);
    int k, cyc, last, stalled;
    bit pulsed;
    k = 0; cyc = 0; last = -1; stalled = 0; pulsed = 0;
    nhs = 0; bad_gap = 0; first_lat = -1;
    while (!done && cyc < 600 && !(stop_after >= 0 && nhs >= stop_after)) begin
      cyc++;
      start = mid_start && (k == 12) && !pulsed;
      if (start) pulsed = 1;
      if (resp_ready && k == stall_idx && stalled < 5) begin
        resp_valid = 1'b0;
        stalled++;
      end else begin
        resp_valid = 1'b1;
      end
      resp_data = (k < 31) ? rsp[k] : 25'h0;
      if (resp_valid && resp_ready) begin
        if (k == 0) first_lat = cyc;
        else if (cyc - last != ((k == stall_idx) ? 7 : 2)) bad_gap++;
        last = cyc;
        nhs++;
        k++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_data = '0;
    m_start = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if ({busy, done, pass, first_fail_vld, resp_ready, exp_rd_en} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b want 000000", {busy, done, pass, first_fail_vld, resp_ready, exp_rd_en}); end
    tests++; if (mismatch_cnt !== 16'h0 || first_fail_idx !== 5'h0 || exp_addr !== 5'h0) begin fails++; $display("FAIL reset_values got cnt=%0d ffi=%0d addr=%0d want 0", mismatch_cnt, first_fail_idx, exp_addr); end
    tests++; if (signature !== 25'h0) begin fails++; $display("FAIL reset_sig got %h want 0", signature); end
  endtask

  task automatic test_clean();
    int rd0;
    set_clean();
    rd0 = rd_cnt;
    pulse_start();
    serve(-1, 0, -1);
    tests++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clean_status got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy); end
    tests++; if (mismatch_cnt !== 16'd0 || first_fail_vld !== 1'b0) begin fails++; $display("FAIL clean_results got cnt=%0d ffv=%b want 0 0", mismatch_cnt, first_fail_vld); end
    tests++; if (nhs !== 31) begin fails++; $display("FAIL clean_handshakes got %0d want 31", nhs); end
    tests++; if (first_lat !== 3 || bad_gap !== 0) begin fails++; $display("FAIL clean_timing got first=%0d badgaps=%0d want 3 0", first_lat, bad_gap); end
    tests++; if (rd_cnt - rd0 !== 31) begin fails++; $display("FAIL clean_rom_reads got %0d want 31", rd_cnt - rd0); end
    tests++; if (signature !== misr_model()) begin fails++; $display("FAIL clean_sig got %h want %h", signature, misr_model()); end
  endtask

  task automatic test_faults();
    set_faults();
    pulse_start();
    serve(-1, 0, -1);
    tests++; if (done !== 1'b1 || pass !== 1'b0) begin fails++; $display("FAIL fault_status got done=%b pass=%b want 1 0", done, pass); end
    tests++; if (mismatch_cnt !== 16'd2) begin fails++; $display("FAIL fault_cnt got %0d want 2", mismatch_cnt); end
    tests++; if (first_fail_idx !== 5'd7 || first_fail_vld !== 1'b1) begin fails++; $display("FAIL fault_first got idx=%0d vld=%b want 7 1", first_fail_idx, first_fail_vld); end
    tests++; if (signature !== misr_model()) begin fails++; $display("FAIL fault_sig got %h want %h", signature, misr_model()); end
  endtask

  task automatic test_restart_from_done();
    int rd0;
    set_clean();
    rd0 = rd_cnt;
    pulse_start();
    tests++; if ({done, pass, first_fail_vld, busy} !== 4'b0001) begin fails++; $display("FAIL restart_flags got %b want 0001", {done, pass, first_fail_vld, busy}); end
    tests++; if (mismatch_cnt !== 16'd0 || signature !== 25'h0) begin fails++; $display("FAIL restart_clear got cnt=%0d sig=%h want 0 0", mismatch_cnt, signature); end
    tests++; if (exp_rd_en !== 1'b1 || exp_addr !== 5'd0) begin fails++; $display("FAIL restart_fetch got rd=%b addr=%0d want 1 0", exp_rd_en, exp_addr); end
    serve(-1, 0, -1);
    tests++; if (done !== 1'b1 || pass !== 1'b1 || nhs !== 31 || rd_cnt - rd0 !== 31) begin fails++; $display("FAIL restart_run got done=%b pass=%b hs=%0d rd=%0d want 1 1 31 31", done, pass, nhs, rd_cnt - rd0); end
  endtask

  task automatic test_backpressure();
    int rd0;
    set_clean();
    rd0 = rd_cnt;
    pulse_start();
    serve(9, 1, -1);
    tests++; if (done !== 1'b1 || pass !== 1'b1 || mismatch_cnt !== 16'd0) begin fails++; $display("FAIL bp_status got done=%b pass=%b cnt=%0d want 1 1 0", done, pass, mismatch_cnt); end
    tests++; if (nhs !== 31 || bad_gap !== 0 || first_lat !== 3) begin fails++; $display("FAIL bp_timing got hs=%0d badgaps=%0d first=%0d want 31 0 3", nhs, bad_gap, first_lat); end
    tests++; if (rd_cnt - rd0 !== 31) begin fails++; $display("FAIL bp_rom_reads got %0d want 31", rd_cnt - rd0); end
    tests++; if (signature !== misr_model()) begin fails++; $display("FAIL bp_sig got %h want %h", signature, misr_model()); end
  endtask

  task automatic test_reset_mid_run();
    int rd0;
    set_faults();
    pulse_start();
    serve(-1, 0, 11);
    tests++; if (mismatch_cnt !== 16'd1 || busy !== 1'b1) begin fails++; $display("FAIL midrst_before got cnt=%0d busy=%b want 1 1", mismatch_cnt, busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({busy, done, pass, first_fail_vld, resp_ready, exp_rd_en} !== 6'b0 || mismatch_cnt !== 16'h0 || signature !== 25'h0 || first_fail_idx !== 5'h0 || exp_addr !== 5'h0) begin fails++; $display("FAIL midrst_outputs got flags=%b cnt=%0d sig=%h want all 0", {busy, done, pass, first_fail_vld, resp_ready, exp_rd_en}, mismatch_cnt, signature); end
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (rd_cnt - rd0 !== 0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_quiet got reads=%0d busy=%b want 0 0", rd_cnt - rd0, busy); end
    set_clean();
    rd0 = rd_cnt;
    pulse_start();
    serve(-1, 0, -1);
    tests++; if (done !== 1'b1 || pass !== 1'b1 || nhs !== 31 || rd_cnt - rd0 !== 31 || signature !== misr_model()) begin fails++; $display("FAIL midrst_fresh got done=%b pass=%b hs=%0d rd=%0d sig=%h want 1 1 31 31 %h", done, pass, nhs, rd_cnt - rd0, signature, misr_model()); end
  endtask

  task automatic test_misr();
    int k, n;
    k = 0; n = 0;
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    while (!m_done && n < 50) begin
      n++;
      m_resp_valid = 1'b1;
      m_resp_data = (k == 0) ? 4'h9 : 4'h6;
      if (m_resp_ready) begin
        k++;
        @(negedge clk);
        if (k == 1) begin
          tests++; if (m_signature !== 4'h9) begin fails++; $display("FAIL misr_vec0 got %h want 9", m_signature); end
        end
      end else begin
        @(negedge clk);
      end
    end
    m_resp_valid = 1'b0;
    tests++; if (m_done !== 1'b1 || m_signature !== 4'h7) begin fails++; $display("FAIL misr_final got done=%b sig=%h want 1 7", m_done, m_signature); end
    tests++; if (m_pass !== 1'b1 || m_mismatch_cnt !== 16'd0) begin fails++; $display("FAIL misr_pass got pass=%b cnt=%0d want 1 0", m_pass, m_mismatch_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 31; i++) rom[i] = 25'(32'(i) * 32'h01357B3D + 32'h00ABCDEF);
    m_rom[0] = 4'h9;
    m_rom[1] = 4'h6;
    test_reset();
    test_clean();
    test_faults();
    test_restart_from_done();
    test_backpressure();
    test_reset_mid_run();
    test_misr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
